// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE / ADD / DONE, 2 bits)
//   DEFAULT_WIDTH : default operand/result width
package adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
//   start, a, b            : request side (driven by master)
//   busy, done, sum, cout  : status/result side (driven by slave)
interface serial_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders; the two half-adder
// carries can never both be set, so an OR merges them.
//   a, b, cin : input bits
//   sum, cout : result bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b  : input bits
//   sum   : a xor b
//   carry : a and b
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// producing the sum LSB-first over WIDTH cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_adder_if (start/a/b in, busy/done/sum/cout out)
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on the accepting edge
// S_ADD  | one result bit per cycle, counter tracks the current bit
// S_DONE | one-cycle done pulse, result registers already updated
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    full_adder u_fa (
        .a   (sa[0]),
        .b   (sb[0]),
        .cin (carry),
        .sum (fa_s),
        .cout(fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ADD;
            S_ADD:   if (last)      state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            ps     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        ps    <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_ADD: begin
                    ps    <= {fa_s, ps[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= fa_c;
                    // Counter holds at WIDTH-1 instead of wrapping; the FSM
                    // leaves ADD on this same edge.
                    if (last) begin
                        sum_q  <= {fa_s, ps[WIDTH-1:1]};
                        cout_q <= fa_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == S_ADD);
    assign bus.done = (state == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
